// File: rtl/majority_gate_bist.sv
`default_nettype none
// ============================================================================
// Module   : majority_gate_bist
// Brief    : On-chip self-test engine for a 3-input majority gate. Steps the
//            gate through all eight input vectors, waits a programmable settle
//            time, samples the gate output and compares it to a golden model.
//            Reports pass/fail, a saturating error count and the first failing
//            vector.
// Revision : 1.0 - initial release
// ============================================================================
module majority_gate_bist #(
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 dut_result,
  output logic                 a,
  output logic                 b,
  output logic                 c,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [2:0]           first_fail_vec,
  output logic                 first_fail_valid
);

  localparam int                   CNT_W        = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]     C_SETTLE_LD  = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0]     C_CNT_ONE    = CNT_W'(1);
  localparam logic [ERR_CNT_W-1:0] C_ERR_MAX    = '1;
  localparam logic [ERR_CNT_W-1:0] C_ERR_ZERO   = '0;
  localparam logic [ERR_CNT_W-1:0] C_ERR_ONE    = ERR_CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [2:0]             vec_q, vec_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   pass_q, pass_d;
  logic [ERR_CNT_W-1:0]   err_q, err_d;
  logic [2:0]             ffvec_q, ffvec_d;
  logic                   ffv_q, ffv_d;
  logic                   w_expected;

  // The stimulus vector register drives the gate directly; it is zero in IDLE
  // and parks at 111 in DONE, so no separate output flops are needed.
  assign a                = vec_q[2];
  assign b                = vec_q[1];
  assign c                = vec_q[0];
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_vec   = ffvec_q;
  assign first_fail_valid = ffv_q;

  // Golden majority of the vector currently applied to the gate.
  assign w_expected = (vec_q[2] & vec_q[1]) | (vec_q[2] & vec_q[0]) | (vec_q[1] & vec_q[0]);

  // Next-state and next-output logic for the test sequencer.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    ffvec_d = ffvec_q;
    ffv_d   = ffv_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        // A new run clears all results of the previous one.
        if (start) begin
          state_d = S_SETTLE;
          vec_d   = 3'b000;
          cnt_d   = C_SETTLE_LD;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = C_ERR_ZERO;
          ffvec_d = 3'b000;
          ffv_d   = 1'b0;
        end
      end

      S_SETTLE: begin
        cnt_d = cnt_q - C_CNT_ONE;
        if (cnt_q == C_CNT_ONE) begin
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if (dut_result != w_expected) begin
          if (err_q != C_ERR_MAX) begin
            err_d = err_q + C_ERR_ONE;
          end
          if (!ffv_q) begin
            ffvec_d = vec_q;
            ffv_d   = 1'b1;
          end
        end
        if (vec_q == 3'b111) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == C_ERR_ZERO);
        end else begin
          state_d = S_SETTLE;
          vec_d   = vec_q + 3'd1;
          cnt_d   = C_SETTLE_LD;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and result registers; reset wins over everything including start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= 3'b000;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ffvec_q <= 3'b000;
      ffv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ffvec_q <= ffvec_d;
      ffv_q   <= ffv_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_majority_gate_bist.sv
`default_nettype none
// ============================================================================
// Module   : tb_majority_gate_bist
// Brief    : Directed self-checking bench for majority_gate_bist. Emulates
//            good, stuck-at and inverted gates behind the engine and checks
//            timing, stimulus sequence and reported results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_majority_gate_bist;

  localparam int C_MODE_GOOD = 0;
  localparam int C_MODE_SA0  = 1;
  localparam int C_MODE_SA1  = 2;
  localparam int C_MODE_INV  = 3;

  logic       clk;
  logic       rst;
  logic       start;
  logic       start_s3;
  int         mode;
  int         checks;
  int         failures;

  // Main instance: SETTLE_CYCLES=1, ERR_CNT_W=4
  logic       a, b, c, busy, done, pass, ffv, res;
  logic [3:0] err;
  logic [2:0] ffvec;

  // Narrow counter instance: SETTLE_CYCLES=1, ERR_CNT_W=2
  logic       a2, b2, c2, busy2, done2, pass2, ffv2, res2;
  logic [1:0] err2;
  logic [2:0] ffvec2;

  // Long settle instance: SETTLE_CYCLES=3, ERR_CNT_W=4
  logic       a3, b3, c3, busy3, done3, pass3, ffv3, res3;
  logic [3:0] err3;
  logic [2:0] ffvec3;

  // Behavioural gate under test, selected by mode.
  function automatic logic gate(input int m, input logic x, input logic y, input logic z);
    logic maj;
    maj = (x & y) | (x & z) | (y & z);
    case (m)
      C_MODE_SA0: gate = 1'b0;
      C_MODE_SA1: gate = 1'b1;
      C_MODE_INV: gate = ~maj;
      default:    gate = maj;
    endcase
  endfunction

  assign res  = gate(mode, a, b, c);
  assign res2 = gate(mode, a2, b2, c2);
  assign res3 = gate(mode, a3, b3, c3);

  majority_gate_bist #(.SETTLE_CYCLES(1), .ERR_CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .dut_result(res),
    .a(a), .b(b), .c(c), .busy(busy), .done(done), .pass(pass),
    .err_count(err), .first_fail_vec(ffvec), .first_fail_valid(ffv)
  );

  majority_gate_bist #(.SETTLE_CYCLES(1), .ERR_CNT_W(2)) dut_w2 (
    .clk(clk), .rst(rst), .start(start), .dut_result(res2),
    .a(a2), .b(b2), .c(c2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .first_fail_vec(ffvec2), .first_fail_valid(ffv2)
  );

  majority_gate_bist #(.SETTLE_CYCLES(3), .ERR_CNT_W(4)) dut_s3 (
    .clk(clk), .rst(rst), .start(start_s3), .dut_result(res3),
    .a(a3), .b(b3), .c(c3), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .first_fail_vec(ffvec3), .first_fail_valid(ffv3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1ns past the last one.
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle start pulse; the returned-to point is just after the sampling edge.
  task automatic pulse_start();
    start = 1'b1;
    edges(1);
    start = 1'b0;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_abc"},   32'({a, b, c}), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(done), 0);
    chk({tag, "_pass"},  32'(pass), 0);
    chk({tag, "_err"},   32'(err), 0);
    chk({tag, "_ffvec"}, 32'(ffvec), 0);
    chk({tag, "_ffv"},   32'(ffv), 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    start    = 1'b0;
    start_s3 = 1'b0;
    mode     = C_MODE_GOOD;

    // Reset state, with start held high to show reset has priority.
    start = 1'b1;
    edges(3);
    start = 1'b0;
    chk_idle_zero("reset");
    chk("reset_s3_busy", 32'(busy3), 0);
    rst = 1'b0;
    edges(2);
    chk("idle_stays_idle", 32'(busy), 0);

    // Good gate: vector sequence, each vector held 2 cycles, done at edge 17.
    mode = C_MODE_GOOD;
    pulse_start();
    chk("good_busy_e1", 32'(busy), 1);
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("good_abc_e%0d", k), 32'({a, b, c}), 32'((k - 1) / 2));
      if (k < 16) edges(1);
    end
    chk("good_done_e16", 32'(done), 0);
    chk("good_busy_e16", 32'(busy), 1);
    edges(1);
    chk("good_done_e17", 32'(done), 1);
    chk("good_busy_e17", 32'(busy), 0);
    chk("good_pass",     32'(pass), 1);
    chk("good_err",      32'(err), 0);
    chk("good_ffv",      32'(ffv), 0);
    chk("good_abc_done", 32'({a, b, c}), 7);
    edges(3);
    chk("good_hold_done", 32'(done), 1);
    chk("good_hold_pass", 32'(pass), 1);

    // Stuck-at-0: fails 011,101,110,111.
    mode = C_MODE_SA0;
    pulse_start();
    chk("sa0_pass_dropped", 32'(pass), 0);
    edges(16);
    chk("sa0_done",  32'(done), 1);
    chk("sa0_err",   32'(err), 4);
    chk("sa0_ffvec", 32'(ffvec), 3);
    chk("sa0_ffv",   32'(ffv), 1);
    chk("sa0_pass",  32'(pass), 0);

    // Inverted gate: all 8 fail; 2-bit counter saturates at 3.
    mode = C_MODE_INV;
    pulse_start();
    edges(16);
    chk("inv_done",    32'(done), 1);
    chk("inv_err",     32'(err), 8);
    chk("inv_ffvec",   32'(ffvec), 0);
    chk("inv_ffv",     32'(ffv), 1);
    chk("inv_pass",    32'(pass), 0);
    chk("inv_w2_done", 32'(done2), 1);
    chk("inv_w2_err",  32'(err2), 3);
    chk("inv_w2_pass", 32'(pass2), 0);

    // Stuck-at-1: fails 000,001,010,100.
    mode = C_MODE_SA1;
    pulse_start();
    edges(16);
    chk("sa1_done",  32'(done), 1);
    chk("sa1_err",   32'(err), 4);
    chk("sa1_ffvec", 32'(ffvec), 0);
    chk("sa1_ffv",   32'(ffv), 1);

    // Restart from DONE with a good gate: results clear immediately.
    mode = C_MODE_GOOD;
    pulse_start();
    chk("restart_done",  32'(done), 0);
    chk("restart_busy",  32'(busy), 1);
    chk("restart_err",   32'(err), 0);
    chk("restart_ffv",   32'(ffv), 0);
    chk("restart_ffvec", 32'(ffvec), 0);
    chk("restart_abc",   32'({a, b, c}), 0);
    edges(16);
    chk("restart_end_done", 32'(done), 1);
    chk("restart_end_pass", 32'(pass), 1);
    chk("restart_end_err",  32'(err), 0);

    // Start pulsed during vector 3 is ignored; completion time unchanged.
    pulse_start();
    edges(6);
    chk("midstart_abc_v3", 32'({a, b, c}), 3);
    pulse_start();
    chk("midstart_abc_after", 32'({a, b, c}), 3);
    chk("midstart_busy",      32'(busy), 1);
    edges(8);
    chk("midstart_done_e16", 32'(done), 0);
    edges(1);
    chk("midstart_done_e17", 32'(done), 1);
    chk("midstart_pass",     32'(pass), 1);

    // Reset during SETTLE of vector 5 returns everything to zero.
    mode = C_MODE_SA0;
    pulse_start();
    edges(10);
    chk("rstmid_abc_v5", 32'({a, b, c}), 5);
    chk("rstmid_ffv_pre", 32'(ffv), 1);
    rst = 1'b1;
    edges(1);
    rst = 1'b0;
    chk_idle_zero("rstmid");
    edges(2);
    chk("rstmid_stays_idle", 32'(busy), 0);

    // Full run after the mid-run reset.
    mode = C_MODE_GOOD;
    pulse_start();
    edges(15);
    chk("postrst_done_e16", 32'(done), 0);
    edges(1);
    chk("postrst_done", 32'(done), 1);
    chk("postrst_pass", 32'(pass), 1);
    chk("postrst_err",  32'(err), 0);

    // SETTLE_CYCLES=3: each vector held 4 cycles, done at edge 33.
    mode     = C_MODE_GOOD;
    start_s3 = 1'b1;
    edges(1);
    start_s3 = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      if ((k % 4) == 1 || (k % 4) == 0) begin
        chk($sformatf("s3_abc_e%0d", k), 32'({a3, b3, c3}), 32'((k - 1) / 4));
      end
      if (k < 32) edges(1);
    end
    chk("s3_done_e32", 32'(done3), 0);
    edges(1);
    chk("s3_done_e33", 32'(done3), 1);
    chk("s3_pass",     32'(pass3), 1);
    chk("s3_err",      32'(err3), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
